spi_frame_loader: RTL and testbench



---
 rtl/spi_frame_loader_if.sv | 18 +
 rtl/spi_frame_loader.sv | 149 ++++++++++++++
 tb/tb_spi_frame_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_loader_if.sv
// SPI pin bundle between an external master and the frame loader.
interface spi_frame_loader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_frame_loader.sv
// SPI-slave register file: double-buffered 64-bit LED frame
// plus live control bytes, committed on the driver frame boundary.
module spi_frame_loader #(
  parameter int MEMORY_COUNT = 12,
  parameter int FRAME_BYTES  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  spi_frame_loader_if.slave             spi,
  input  logic                          frame_done,
  output logic [63:0]                   frame_buffer,
  output logic [8*(MEMORY_COUNT-8)-1:0] ctrl_regs,
  output logic                          commit_pending
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;

  state_e     state_q;
  logic [2:0] bit_q;
  logic [6:0] sh_q;
  logic       rd_q;
  logic [3:0] addr_q;
  logic       load_q;
  logic [7:0] tx_q;
  logic       dirty_q;
  logic       pend_q;
  logic       oe_q;
  logic [7:0] mem_q   [MEMORY_COUNT];
  logic [7:0] frame_q [FRAME_BYTES];

  logic       rise;
  logic       fall;
  logic       cs_on;
  logic [7:0] byte_d;
  logic       in_range;
  logic [7:0] rd_byte;
  logic [3:0] addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_sclk};
      cs_q   <= {cs_q[0], spi.spi_cs_n};
      mosi_q <= {mosi_q[0], spi.spi_mosi};
    end
  end

  assign rise     = sclk_q[1] & ~sclk_q[2];
  assign fall     = ~sclk_q[1] & sclk_q[2];
  assign cs_on    = ~cs_q[1];
  assign byte_d   = {sh_q, mosi_q[1]};
  assign in_range = {1'b0, addr_q} < 5'(MEMORY_COUNT);
  assign rd_byte  = in_range ? mem_q[addr_q] : 8'h00;
  assign addr_d   = (addr_q == 4'(MEMORY_COUNT-1))
                  ? 4'd0 : addr_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      tx_q    <= '0;
      dirty_q <= 1'b0;
      pend_q  <= 1'b0;
      oe_q    <= 1'b0;
      for (int i = 0; i < MEMORY_COUNT; i++) mem_q[i] <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) frame_q[i] <= '0;
    end else begin
      oe_q <= cs_on;
      // Nonblocking copy takes the pre-write shadow on a clash.
      if (frame_done && pend_q) begin
        for (int i = 0; i < FRAME_BYTES; i++) frame_q[i] <= mem_q[i];
        pend_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          tx_q <= '0;
          if (cs_on) begin
            state_q <= CMD;
            bit_q   <= '0;
            load_q  <= 1'b0;
          end
        end
        default: begin
          if (!cs_on) begin
            state_q <= IDLE;
            tx_q    <= '0;
            if (dirty_q) begin
              pend_q  <= 1'b1;
              dirty_q <= 1'b0;
            end
          end else begin
            if (rise) begin
              sh_q  <= byte_d[6:0];
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                load_q <= 1'b1;
                if (state_q == CMD) begin
                  state_q <= DATA;
                  rd_q    <= byte_d[7];
                  addr_q  <= byte_d[3:0];
                end else begin
                  addr_q <= addr_d;
                  if (!rd_q && in_range) begin
                    mem_q[addr_q] <= byte_d;
                    if (addr_q < 4'(FRAME_BYTES)) dirty_q <= 1'b1;
                  end
                end
              end
            end
            if (fall) begin
              load_q <= 1'b0;
              if (load_q && rd_q) tx_q <= rd_byte;
              else                tx_q <= {tx_q[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign spi.spi_miso    = tx_q[7];
  assign spi.spi_miso_oe = oe_q;
  assign commit_pending  = pend_q;

  always_comb begin
    frame_buffer = '0;
    for (int i = 0; i < FRAME_BYTES; i++) frame_buffer[8*i +: 8] = frame_q[i];
  end

  for (genvar k = 0; k < MEMORY_COUNT-8; k++) begin : g_ctrl
    assign ctrl_regs[8*k +: 8] = mem_q[FRAME_BYTES+k];
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench for spi_frame_loader: vector table
// plus hand sequences, read data checked through a queue.
module tb_spi_frame_loader;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_done;
  logic [63:0] frame_buffer;
  logic [31:0] ctrl_regs;
  logic        commit_pending;

  spi_frame_loader_if spi ();

  spi_frame_loader #(
    .MEMORY_COUNT(12),
    .FRAME_BYTES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi.slave),
    .frame_done    (frame_done),
    .frame_buffer  (frame_buffer),
    .ctrl_regs     (ctrl_regs),
    .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  d0, d1;
    logic [7:0]  r0, r1;
    logic [31:0] ctrl;
    logic        pend;
  } vec_t;

  vec_t       vecs [5];
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx;
  bit         seen;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits(input logic [7:0] tx, input int n,
                      output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi.spi_mosi = tx[i];
      tick(H);
      r[i] = spi.spi_miso;
      spi.spi_sclk = 1'b1;
      tick(H);
      spi.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi.spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    tick(H);
    spi.spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d0,
                     input logic [7:0] d1);
    logic [7:0] r;
    cs_lo();
    bits({4'h0, a}, 8, r);
    chk("wr cmd miso", r, 0);
    bits(d0, 8, r);
    chk("wr d0 miso", r, 0);
    bits(d1, 8, r);
    chk("wr d1 miso", r, 0);
    cs_hi();
  endtask

  task automatic rd(input logic [3:0] a, input int n);
    logic [7:0] r;
    logic [7:0] e;
    cs_lo();
    chk("miso_oe on", spi.spi_miso_oe, 1);
    bits({4'h8, a}, 8, r);
    chk("rd cmd miso", r, 0);
    for (int i = 0; i < n; i++) begin
      bits(8'h00, 8, r);
      if (exp_q.size() == 0) begin
        chk("rd queue empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rd a%0h b%0d", a, i), r, e);
      end
    end
    cs_hi();
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    tick(2);
  endtask

  initial begin
    vecs[0] = '{4'hA, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 32'h5AA5_0000, 1'b0};
    vecs[1] = '{4'hB, 8'h01, 8'h02, 8'h01, 8'h02, 32'h01A5_0000, 1'b1};
    vecs[2] = '{4'h3, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 32'h01A5_0000, 1'b1};
    vecs[3] = '{4'hE, 8'h77, 8'h88, 8'h00, 8'h00, 32'h01A5_0000, 1'b1};
    vecs[4] = '{4'h5, 8'h5A, 8'h0F, 8'h5A, 8'h0F, 32'h01A5_0000, 1'b1};

    spi.spi_sclk = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    frame_done   = 1'b0;
    rst_n        = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    chk("rst frame", frame_buffer, 0);
    chk("rst ctrl", ctrl_regs, 0);
    chk("rst pend", commit_pending, 0);
    chk("rst miso", spi.spi_miso, 0);
    chk("rst oe", spi.spi_miso_oe, 0);

    cs_lo();
    bits(8'h00, 8, rx);
    for (int i = 0; i < 8; i++) bits(8'(8'h11 * (i + 1)), 8, rx);
    cs_hi();
    chk("frame pre-commit", frame_buffer, 0);
    chk("pend set", commit_pending, 1);
    pulse_fd();
    chk("frame commit", frame_buffer, 64'h8877_6655_4433_2211);
    chk("pend clear", commit_pending, 0);

    for (int v = 0; v < 5; v++) begin
      wr2(vecs[v].a, vecs[v].d0, vecs[v].d1);
      chk($sformatf("vec%0d ctrl", v), ctrl_regs, vecs[v].ctrl);
      chk($sformatf("vec%0d pend", v), commit_pending, vecs[v].pend);
      exp_q.push_back(vecs[v].r0);
      exp_q.push_back(vecs[v].r1);
      rd(vecs[v].a, 2);
    end
    chk("frame before 2nd commit", frame_buffer, 64'h8877_6655_4433_2211);
    pulse_fd();
    chk("frame 2nd commit", frame_buffer, 64'h880F_5AC3_3C33_2202);
    chk("pend after 2nd", commit_pending, 0);

    cs_lo();
    bits(8'h02, 8, rx);
    bits(8'h99, 8, rx);
    tick(H);
    spi.spi_cs_n = 1'b1;
    frame_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = commit_pending;
    end
    frame_done = 1'b0;
    chk("pend rise seen", seen, 1);
    tick(2);
    chk("no commit same cycle", frame_buffer, 64'h880F_5AC3_3C33_2202);
    chk("pend held", commit_pending, 1);
    pulse_fd();
    chk("late commit", frame_buffer, 64'h880F_5AC3_3C99_2202);

    cs_lo();
    bits(8'h02, 8, rx);
    bits(8'h5A, 5, rx);
    cs_hi();
    chk("abort no pend", commit_pending, 0);
    exp_q.push_back(8'h99);
    rd(4'h2, 1);

    wr2(4'h0, 8'h55, 8'h66);
    chk("pend before rst", commit_pending, 1);
    cs_lo();
    bits(8'h00, 3, rx);
    rst_n = 1'b0;
    tick(1);
    chk("mid rst frame", frame_buffer, 0);
    chk("mid rst ctrl", ctrl_regs, 0);
    chk("mid rst pend", commit_pending, 0);
    chk("mid rst miso", spi.spi_miso, 0);
    chk("mid rst oe", spi.spi_miso_oe, 0);
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    pulse_fd();
    chk("post rst frame", frame_buffer, 0);
    wr2(4'h8, 8'h42, 8'h24);
    chk("post rst ctrl", ctrl_regs, 32'h0000_2442);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
